// File: rtl/alu_op_encoder.sv
// Decode-and-issue stage ahead of the ALU: encodes the 3-bit ALU control, picks operand B and
// buffers decoded ops in a 2-entry FIFO. Define ALU_ENC_BRANCH_EN to also encode beq/bne.
module alu_op_encoder #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  output logic            illegal,
  output logic            is_branch,
  output logic            br_ne
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
`ifdef ALU_ENC_BRANCH_EN
  localparam logic [6:0] OpcBranch = 7'b1100011;
`endif

  localparam logic [2:0] CtrlAdd  = 3'b000;
  localparam logic [2:0] CtrlSub  = 3'b001;
  localparam logic [2:0] CtrlAnd  = 3'b010;
  localparam logic [2:0] CtrlOr   = 3'b011;
  localparam logic [2:0] CtrlSltu = 3'b101;
  localparam logic [2:0] CtrlXor  = 3'b110;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      ctrl;
    logic            ill;
`ifdef ALU_ENC_BRANCH_EN
    logic            br;
    logic            ne;
`endif
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       legal;
  logic       use_imm;
  logic [2:0] ctrl;
  entry_t     dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    legal   = 1'b0;
    use_imm = 1'b0;
    ctrl    = CtrlAdd;
    dec     = '0;
    case (opcode)
      OpcOp: begin
        legal = 1'b1;
        case (funct3)
          3'b000:  ctrl = instr[30] ? CtrlSub : CtrlAdd;
          3'b111:  ctrl = CtrlAnd;
          3'b110:  ctrl = CtrlOr;
          3'b011:  ctrl = CtrlSltu;
          3'b100:  ctrl = CtrlXor;
          default: legal = 1'b0;
        endcase
      end
      OpcOpImm: begin
        legal   = 1'b1;
        use_imm = 1'b1;
        case (funct3)
          3'b000:  ctrl = CtrlAdd;
          3'b111:  ctrl = CtrlAnd;
          3'b110:  ctrl = CtrlOr;
          3'b011:  ctrl = CtrlSltu;
          3'b100:  ctrl = CtrlXor;
          default: legal = 1'b0;
        endcase
      end
      OpcLoad, OpcStore: begin
        legal   = 1'b1;
        use_imm = 1'b1;
        ctrl    = CtrlAdd;
      end
`ifdef ALU_ENC_BRANCH_EN
      OpcBranch: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          legal  = 1'b1;
          ctrl   = CtrlSub;
          dec.br = 1'b1;
          dec.ne = funct3[0];
        end
      end
`endif
      default: legal = 1'b0;
    endcase
    // Illegal ops still travel down the pipe, but with zeroed operands.
    if (legal) begin
      dec.a    = rs1_val;
      dec.b    = use_imm ? imm : rs2_val;
      dec.ctrl = ctrl;
    end else begin
      dec = '0;
    end
    dec.ill = ~legal;
  end

  logic [1:0] count_q, count_d;
  logic       rd_q, wr_q;
  logic       in_ready_q;
  logic       accept, issue;
  entry_t     mem_q [2];
  entry_t     head;

  assign accept    = in_valid && in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign issue     = out_valid && out_ready;
  assign in_ready  = in_ready_q;

  always_comb begin
    count_d = count_q;
    if (accept && !issue) count_d = count_q + 2'd1;
    if (issue && !accept) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      if (accept) wr_q <= ~wr_q;
      if (issue)  rd_q <= ~rd_q;
    end
  end

  // Payload needs no reset: outputs are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= dec;
  end

  assign head     = mem_q[rd_q];
  assign alu_a    = out_valid ? head.a : '0;
  assign alu_b    = out_valid ? head.b : '0;
  assign alu_ctrl = out_valid ? head.ctrl : 3'b000;
  assign illegal  = out_valid & head.ill;

`ifdef ALU_ENC_BRANCH_EN
  assign is_branch = out_valid & head.br;
  assign br_ne     = out_valid & head.ne;
`else
  assign is_branch = 1'b0;
  assign br_ne     = 1'b0;
`endif

endmodule

// File: doc/alu_op_encoder.md
# alu_op_encoder

Registered decode-and-issue stage that sits upstream of the single-cycle ALU in the RV32 datapath. It accepts an instruction word with its operand values over a valid/ready handshake, encodes the 3-bit ALU control and selects operand B. It issues the result to the ALU stage through a 2-entry buffer, so neither side stalls the other combinationally. It is the producing end of the ALU `Control` encoding.

## Interface
- `XLEN`, default 32: operand width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: instruction/operands valid.
- `in_ready` out 1: encoder can accept this cycle.
- `instr` in 32: RV32 instruction word.
- `rs1_val` in XLEN: rs1 register value.
- `rs2_val` in XLEN: rs2 register value.
- `imm` in XLEN: sign-extended immediate from the immediate generator.
- `out_valid` out 1: issued op valid.
- `out_ready` in 1: ALU stage accepts.
- `alu_a` out XLEN: operand A, always rs1_val.
- `alu_b` out XLEN: operand B, rs2_val or imm.
- `alu_ctrl` out 3: ALU control code.
- `illegal` out 1: op not encodable.
- `is_branch` out 1: branch compare op (`ALU_ENC_BRANCH_EN` only; else tied 0).
- `br_ne` out 1: branch taken when Zero=0 (`ALU_ENC_BRANCH_EN` only; else tied 0).

## Operation
- Control codes: 000 add, 001 sub, 010 and, 011 or, 101 unsigned less-than, 110 xor. 100 and 111 are never emitted.
- OP (opcode 0110011), B=rs2_val:
  - funct3 000 with funct7[5]=0 → 000; with funct7[5]=1 → 001.
  - 111 → 010, 110 → 011, 011 → 101, 100 → 110.
  - All other funct3 (sll, slt, srl/sra) → illegal.
- OP-IMM (0010011), B=imm:
  - 000 → 000, 111 → 010, 110 → 011, 011 → 101, 100 → 110.
  - Others → illegal.
- LOAD (0000011) and STORE (0100011): 000, B=imm (address add). funct3 is not checked.
- Any other opcode → illegal.
- Illegal entry: `alu_ctrl`=000, `alu_a`=`alu_b`=0, `illegal`=1. It is still issued as one beat and never dropped.
- Buffer: 2-entry FIFO of decoded entries, with a count of 0..2.
  - Accept when `in_valid && in_ready`; issue when `out_valid && out_ready`.
  - `in_ready` = count<2, registered and independent of `out_ready`.
  - `out_valid` = count>0.
  - The output fields show the head entry and hold stable while `out_valid && !out_ready`.
- Simultaneous accept and issue: count is unchanged, order is preserved.
  - At count=1, the new entry becomes head the cycle after the old head issues.
  - At count=2, accept is impossible (`in_ready`=0).
- Entries with no accept are never written. There is no bypass from input to output.

## Timing
- Latency: an entry accepted at edge N is presented with `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: 1 op/cycle with `out_ready` held high.
- Back-pressure:
  - With `out_ready`=0, two entries are accepted and then `in_ready` drops the cycle after the second accept.
  - `in_ready` returns to 1 the cycle after the first issue.
- Reset (`rst_n`=0 at an edge):
  - count=0, `out_valid`=0, `in_ready`=1.
  - `alu_a`, `alu_b`=0; `alu_ctrl`=000; `illegal`, `is_branch`, `br_ne`=0.
  - In-flight entries are discarded; reset mid-stall loses both entries.
- Inputs are sampled only on accept edges.

## Configuration
- `ALU_ENC_BRANCH_EN` defined:
  - BRANCH (1100011) funct3 000 (beq) → `alu_ctrl`=001, B=rs2_val, `is_branch`=1, `br_ne`=0.
  - funct3 001 (bne) → same, with `br_ne`=1.
  - Other branch funct3 → illegal.
  - `is_branch` and `br_ne` are stored per entry.
- Undefined: BRANCH is illegal; `is_branch` and `br_ne` are constant 0 and no storage is built for them.

## Test plan
- Reset with `rst_n`=0 for 2 cycles → `out_valid`=0, `in_ready`=1, all outputs 0.
- OP sub: instr 0x40208033, rs1_val=10, rs2_val=3, `out_ready`=1 → next cycle `alu_ctrl`=001, `alu_a`=10, `alu_b`=3, `illegal`=0.
- OP-IMM sltiu: instr 0x0050B013, imm=5 → `alu_ctrl`=101, `alu_b`=5. Then sll 0x00209033 → `illegal`=1, `alu_ctrl`=000, `alu_a`=`alu_b`=0.
- Back-pressure:
  - Hold `out_ready`=0 and push addi, andi, ori on consecutive cycles → first two accepted, `in_ready`=0 on the third and ori held.
  - Raise `out_ready` → issue order is 000, 010, then 011, with no duplicates and no loss.
- Streaming: 8 back-to-back lw ops with `out_ready`=1 → 8 consecutive `out_valid` cycles, each `alu_ctrl`=000, `alu_b`=imm.
- Branch with `ALU_ENC_BRANCH_EN`: bne 0x00209463 → `alu_ctrl`=001, `is_branch`=1, `br_ne`=1. Without the macro, the same word gives `illegal`=1 and `is_branch`=0.
